// File: rtl/branch_resolver_pkg.sv
// Shared types for the execute-stage branch resolver: operation encoding
// (branch codes equal funct3) and FSM states.
package branch_pkg;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    JAL  = 3'b010,
    JALR = 3'b011,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } br_op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } br_state_e;

endpackage

// File: rtl/branch_resolver_if.sv
// ID/EX-to-resolver bundle: branch operands in, redirect/flush/statistics out.
interface branch_resolver_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            stall;
  logic [2:0]      br_op;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush_ifid;
  logic            flush_idex;
  logic            busy;
  logic [31:0]     branch_cnt;
  logic [31:0]     taken_cnt;

  modport master (
    output in_valid, stall, br_op, rs1_val, rs2_val, pc, imm,
    input  redirect_valid, redirect_pc, flush_ifid, flush_idex, busy,
           branch_cnt, taken_cnt
  );

  modport slave (
    input  in_valid, stall, br_op, rs1_val, rs2_val, pc, imm,
    output redirect_valid, redirect_pc, flush_ifid, flush_idex, busy,
           branch_cnt, taken_cnt
  );
endinterface

// File: rtl/branch_resolver_cond.sv
// Branch condition evaluation: purely combinational taken decision.
module branch_cond
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      br_op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            taken
);

  // Decode operation and compare operands (signed for BLT/BGE, unsigned for *U).
  always_comb begin
    taken = 1'b0;
    case (br_op_e'(br_op))
      BEQ:       taken = (rs1_val == rs2_val);
      BNE:       taken = (rs1_val != rs2_val);
      JAL, JALR: taken = 1'b1;
      BLT:       taken = ($signed(rs1_val) <  $signed(rs2_val));
      BGE:       taken = ($signed(rs1_val) >= $signed(rs2_val));
      BLTU:      taken = (rs1_val <  rs2_val);
      BGEU:      taken = (rs1_val >= rs2_val);
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: evaluates the condition, computes the target,
// issues a registered PC redirect and a FLUSH_CYCLES-long pipeline flush.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rstn,
  branch_resolver_if.slave   bus
);

  br_state_e       state;
  logic [3:0]      flush_left;
  logic            taken;
  logic [XLEN-1:0] pc_sum;
  logic [XLEN-1:0] reg_sum;
  logic [XLEN-1:0] target;
  logic            redirect_valid_q;
  logic [XLEN-1:0] redirect_pc_q;
  logic            flush_q;
  logic            busy_q;
  logic [31:0]     branch_cnt_q;
  logic [31:0]     taken_cnt_q;

  branch_cond #(.XLEN(XLEN)) u_cond (
    .br_op   (bus.br_op),
    .rs1_val (bus.rs1_val),
    .rs2_val (bus.rs2_val),
    .taken   (taken)
  );

  // Target adder: pc-relative for branches/JAL, register-relative with bit 0 cleared for JALR.
  always_comb begin
    pc_sum  = bus.pc + bus.imm;
    reg_sum = bus.rs1_val + bus.imm;
    target  = pc_sum;
    if (br_op_e'(bus.br_op) == JALR) target = {reg_sum[XLEN-1:1], 1'b0};
  end

  // Resolution FSM with registered redirect, flush, busy and statistics; stall freezes everything.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state            <= IDLE;
      flush_left       <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      busy_q           <= 1'b0;
      branch_cnt_q     <= '0;
      taken_cnt_q      <= '0;
    end else if (!bus.stall) begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            branch_cnt_q <= branch_cnt_q + 32'd1;
            if (taken) begin
              taken_cnt_q      <= taken_cnt_q + 32'd1;
              redirect_pc_q    <= target;
              redirect_valid_q <= 1'b1;
              flush_q          <= 1'b1;
              busy_q           <= 1'b1;
              flush_left       <= 4'(FLUSH_CYCLES - 1);
              state            <= FLUSH;
            end
          end
        end
        FLUSH: begin
          // Wrong-path in_valid is ignored here; the redirect pulse ends after one unstalled cycle.
          redirect_valid_q <= 1'b0;
          if (flush_left == '0) begin
            flush_q <= 1'b0;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end else begin
            flush_left <= flush_left - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush_ifid     = flush_q;
  assign bus.flush_idex     = flush_q;
  assign bus.busy           = busy_q;
  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.taken_cnt      = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: vector table, directed corner
// sequences and randomized traffic against a behavioural reference model.
module tb_branch_resolver;

  localparam int XLEN = 32;
  localparam int FC   = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int          m_remaining;   // flush-high unstalled cycles still owed
  bit          m_rv;
  logic [31:0] m_rpc;
  logic [31:0] m_bc;
  logic [31:0] m_tc;

  branch_resolver_if #(.XLEN(XLEN)) bus ();

  branch_resolver #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [31:0] imm;
    bit          exp_taken;
    logic [31:0] exp_target;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_taken(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    case (op)
      3'd0:       return ua == ub;
      3'd1:       return ua != ub;
      3'd2, 3'd3: return 1'b1;
      3'd4:       return sa < sb;
      3'd5:       return sa >= sb;
      3'd6:       return ua < ub;
      default:    return ua >= ub;
    endcase
  endfunction

  function automatic logic [31:0] ref_target(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] p, input logic [31:0] i);
    logic [31:0] s;
    if (op == 3'd3) begin
      s = a + i;
      s[0] = 1'b0;
    end else begin
      s = p + i;
    end
    return s;
  endfunction

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic step();
    logic        r  = rstn;
    logic        s  = bus.stall;
    logic        v  = bus.in_valid;
    logic [2:0]  op = bus.br_op;
    logic [31:0] a  = bus.rs1_val;
    logic [31:0] b  = bus.rs2_val;
    logic [31:0] p  = bus.pc;
    logic [31:0] i  = bus.imm;
    @(posedge clk);
    if (!r) begin
      m_remaining = 0; m_rv = 0; m_rpc = '0; m_bc = '0; m_tc = '0;
    end else if (!s) begin
      if (m_remaining > 0) begin
        m_remaining--;
        m_rv = 0;
      end else if (v) begin
        m_bc = m_bc + 1;
        if (ref_taken(op, a, b)) begin
          m_tc = m_tc + 1;
          m_rpc = ref_target(op, a, p, i);
          m_rv = 1;
          m_remaining = FC;
        end
      end
    end
    #1;
    chk("redirect_valid", 32'(bus.redirect_valid), 32'(m_rv));
    chk("redirect_pc",    bus.redirect_pc,         m_rpc);
    chk("flush_ifid",     32'(bus.flush_ifid),     32'(m_remaining > 0));
    chk("flush_idex",     32'(bus.flush_idex),     32'(m_remaining > 0));
    chk("busy",           32'(bus.busy),           32'(m_remaining > 0));
    chk("branch_cnt",     bus.branch_cnt,          m_bc);
    chk("taken_cnt",      bus.taken_cnt,           m_tc);
  endtask

  task automatic drive(input bit v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] p, input logic [31:0] i);
    bus.in_valid = v;
    bus.br_op    = op;
    bus.rs1_val  = a;
    bus.rs2_val  = b;
    bus.pc       = p;
    bus.imm      = i;
  endtask

  task automatic idle_steps(input int n);
    bus.in_valid = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    bus.stall = 1'b0;
    bus.in_valid = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  initial begin
    int pulses;
    logic [31:0] bc0;

    bus.stall = 1'b0;
    drive(0, 3'd0, '0, '0, '0, '0);

    vecs.push_back('{3'd0, 32'h5,        32'h5, 32'h100,      32'h20, 1, 32'h120});
    vecs.push_back('{3'd4, 32'hFFFFFFFF, 32'h1, 32'h200,      32'h8,  1, 32'h208});
    vecs.push_back('{3'd6, 32'hFFFFFFFF, 32'h1, 32'h200,      32'h8,  0, 32'h0});
    vecs.push_back('{3'd3, 32'h1001,     32'h0, 32'h400,      32'h4,  1, 32'h1004});
    vecs.push_back('{3'd2, 32'h0,        32'h0, 32'hFFFFFFF0, 32'h20, 1, 32'h10});
    vecs.push_back('{3'd1, 32'h7,        32'h7, 32'h300,      32'h10, 0, 32'h0});
    vecs.push_back('{3'd5, 32'hFFFFFFFF, 32'h1, 32'h300,      32'h10, 0, 32'h0});
    vecs.push_back('{3'd7, 32'hFFFFFFFF, 32'h1, 32'h300,      32'hFFFFFFF0, 1, 32'h2F0});
    vecs.push_back('{3'd5, 32'h3,        32'h3, 32'h40,       32'h4,  1, 32'h44});

    // Reset state
    do_reset();
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_redirect_pc", bus.redirect_pc, 32'd0);

    // Vector table: each from IDLE, then drained back to IDLE
    foreach (vecs[n]) begin
      drive(1, vecs[n].op, vecs[n].rs1, vecs[n].rs2, vecs[n].pc, vecs[n].imm);
      step();
      chk($sformatf("vec%0d_taken", n), 32'(bus.redirect_valid), 32'(vecs[n].exp_taken));
      if (vecs[n].exp_taken) chk($sformatf("vec%0d_target", n), bus.redirect_pc, vecs[n].exp_target);
      idle_steps(FC + 1);
    end

    // Wrong-path in_valid during flush is ignored
    do_reset();
    drive(1, 3'd1, 32'h1, 32'h2, 32'h500, 32'h40);
    step();
    pulses = int'(bus.redirect_valid);
    drive(1, 3'd0, 32'h9, 32'h9, 32'h600, 32'h8);
    for (int k = 0; k < FC; k++) begin
      step();
      pulses += int'(bus.redirect_valid);
    end
    bus.in_valid = 1'b0;
    chk("wrongpath_branch_cnt", bus.branch_cnt, 32'd1);
    chk("wrongpath_pulses", 32'(pulses), 32'd1);
    idle_steps(2);

    // Stall in the first flush cycle holds redirect and flushes
    do_reset();
    drive(1, 3'd0, 32'h5, 32'h5, 32'h100, 32'h20);
    step();
    bus.in_valid = 1'b0;
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_rv_held", 32'(bus.redirect_valid), 32'd1);
      chk("stall_flush_held", 32'(bus.flush_ifid), 32'd1);
    end
    bus.stall = 1'b0;
    step();
    chk("post_stall_rv", 32'(bus.redirect_valid), 32'd0);
    chk("post_stall_flush2", 32'(bus.flush_idex), 32'd1);
    step();
    chk("post_stall_flush_end", 32'(bus.flush_idex), 32'd0);
    chk("stall_taken_cnt", bus.taken_cnt, 32'd1);

    // Reset mid-flush, then immediate fresh accept
    drive(1, 3'd2, 32'h0, 32'h0, 32'h1000, 32'h100);
    step();
    bus.in_valid = 1'b0;
    rstn = 1'b0;
    step();
    chk("midflush_reset_busy", 32'(bus.busy), 32'd0);
    chk("midflush_reset_flush", 32'(bus.flush_ifid), 32'd0);
    chk("midflush_reset_cnt", bus.branch_cnt, 32'd0);
    rstn = 1'b1;
    drive(1, 3'd0, 32'h5, 32'h5, 32'h100, 32'h20);
    step();
    chk("fresh_accept_rv", 32'(bus.redirect_valid), 32'd1);
    chk("fresh_accept_pc", bus.redirect_pc, 32'h120);
    idle_steps(FC + 1);

    // Randomized traffic against the model
    bc0 = bus.branch_cnt;
    for (int k = 0; k < 400; k++) begin
      logic [31:0] a = $urandom;
      logic [31:0] b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      rstn = ($urandom_range(0, 49) != 0);
      bus.stall = ($urandom_range(0, 4) == 0);
      drive($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), a, b, $urandom, $urandom);
      step();
    end
    chk("random_activity", 32'(bus.branch_cnt != bc0 || m_bc == bus.branch_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
